twiddle_fetch: RTL
==================

TWIDDLE_FETCH -- requirements
Module: twiddle_fetch

Interface
REQ-001 SHALL have parameter N, default 16, FFT length (power of two, at least 4).
REQ-002 SHALL have parameter LOG_N, default 4, log2(N).
REQ-003 SHALL have parameter TF_WIDTH, default 32, packed twiddle width: {real[31:16], imag[15:0]}, both signed Q1.14.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a full N-point schedule.
- tf_addr  out  LOG_N-1  twiddle ROM address.
- tf_addr_nd  out  1  ROM read strobe.
- tf_in  in  TF_WIDTH  ROM data, valid the cycle after a strobed address.
- out_valid  out  1  output holds a twiddle.
- out_ready  in  1  consumer accepts the output.
- out_tf  out  TF_WIDTH  twiddle value.
- out_stage  out  log2(LOG_N)  FFT stage of out_tf.
- out_bfly  out  LOG_N-1  butterfly index of out_tf within its stage.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse after the final handshake.

Function
REQ-005 SHALL issue, for each stage s = 0..LOG_N-1 and each butterfly b = 0..N/2-1 (b inner, s outer), exactly one strobe with tf_addr = (b mod 2^s) << (LOG_N-1-s).
REQ-006 SHALL have FSM states IDLE, RUN and DRAIN; IDLE->RUN on start; RUN->DRAIN after the last strobe; DRAIN->IDLE on the final out_valid&&out_ready.
REQ-007 SHALL ignore start while busy is high.
REQ-008 SHALL capture tf_in exactly one cycle after each strobe into a 2-entry FIFO, tagged with that strobe's stage and butterfly.
REQ-009 SHALL strobe only when (entries in flight + entries buffered) < 2, so data is never lost under backpressure.
REQ-010 SHALL present out_valid from the FIFO head, with out_tf/out_stage/out_bfly held stable while out_valid && !out_ready.
REQ-011 SHALL sustain one output per cycle while out_ready is held high; the first out_valid comes 2 cycles after start.
REQ-012 SHALL emit outputs in strobe order, N/2*LOG_N in total (32 at defaults).
REQ-013 SHALL drive tf_addr to 0 whenever tf_addr_nd is low.
REQ-014 SHALL hold busy high from the cycle after start until the cycle done is high; done and busy are never both high.

Reset
REQ-015 SHALL, while rst_n is low at a clock edge, set: state IDLE, FIFO empty, counters 0, out_valid 0, tf_addr_nd 0, tf_addr 0, out_tf 0, out_stage 0, out_bfly 0, busy 0, done 0.
REQ-016 SHALL abort any schedule when reset is asserted mid-run, producing no done pulse; a ROM return in the cycle after reset SHALL be discarded.

Configuration
REQ-017 SHALL, with TWIDDLE_FETCH_CONJ_EN defined, output the conjugate (imag negated, -32768 saturated to 32767) for inverse FFT; without it, SHALL pass tf_in unchanged.

Structure
REQ-018 SHALL place the FSM state enum, TF_WIDTH and the real/imag field slicing constants in shared package fft_pkg.
REQ-019 SHALL implement the 2-entry tagged FIFO as sub-module tf_skid_fifo.

Verification
REQ-020 SHALL check: start, out_ready=1 -> 32 outputs on consecutive cycles; stage 0 all addr 0; stage 3 addrs 0..7; done 1 cycle after the 32nd handshake.
REQ-021 SHALL check: out_ready toggling 1/0 each cycle -> identical 32-value sequence, no drop or duplicate, outputs stable while stalled.
REQ-022 SHALL check: out_ready=0 for 10 cycles after start -> at most 2 strobes, out_valid held with stage 0 bfly 0 value {16384,0}.
REQ-023 SHALL check: second start pulse at output 5 -> ignored, still exactly 32 outputs and one done.
REQ-024 SHALL check: rst_n low at output 12 -> all outputs at reset values the next cycle, no done; a new start then yields a full 32-output run.
REQ-025 SHALL check: TWIDDLE_FETCH_CONJ_EN defined, ROM addr 2 -> out_tf = {11585, 11585}.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT types: FSM state encoding and packed twiddle field layout.
// Twiddles are {real, imag}, each signed Q1.14 in a 16-bit half-word.
package fft_pkg;

    localparam int TF_WIDTH = 32;
    localparam int HALF_W   = 16;
    localparam int RE_MSB   = 31;
    localparam int RE_LSB   = 16;
    localparam int IM_MSB   = 15;
    localparam int IM_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tf_state_e;

    // Complex conjugate; the single unrepresentable negation saturates.
    function automatic logic [TF_WIDTH-1:0] tf_conj(
        input logic [TF_WIDTH-1:0] tf
    );
        logic [HALF_W-1:0] im;
        logic [HALF_W-1:0] neg;
        im = tf[IM_MSB:IM_LSB];
        if (im == 16'h8000) begin
            neg = 16'h7fff;
        end else begin
            neg = (~im) + 16'd1;
        end
        return {tf[RE_MSB:RE_LSB], neg};
    endfunction

endpackage

// File: rtl/tf_skid_fifo.sv
// Two-entry FIFO holding ROM returns tagged with stage and butterfly.
// Head is presented directly from storage so it stays stable under stall.
module tf_skid_fifo
    import fft_pkg::*;
#(
    parameter int DW = 32,
    parameter int SW = 2,
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_tf,
    input  logic [SW-1:0] push_stage,
    input  logic [BW-1:0] push_bfly,
    input  logic          pop,
    output logic          head_valid,
    output logic [DW-1:0] head_tf,
    output logic [SW-1:0] head_stage,
    output logic [BW-1:0] head_bfly,
    output logic [1:0]    count
);

    logic [DW-1:0] tf_q    [2];
    logic [SW-1:0] stage_q [2];
    logic [BW-1:0] bfly_q  [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    // Entry storage: write the tail slot on push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                tf_q[i]    <= '0;
                stage_q[i] <= '0;
                bfly_q[i]  <= '0;
            end
        end else if (do_push) begin
            tf_q[wr_ptr_q]    <= push_tf;
            stage_q[wr_ptr_q] <= push_stage;
            bfly_q[wr_ptr_q]  <= push_bfly;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_valid = (cnt_q != 2'd0);
    assign head_tf    = tf_q[rd_ptr_q];
    assign head_stage = stage_q[rd_ptr_q];
    assign head_bfly  = bfly_q[rd_ptr_q];
    assign count      = cnt_q;

endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle fetch sequencer: walks the FFT stage/butterfly schedule, reads
// the ROM and streams tagged twiddles. TWIDDLE_FETCH_CONJ_EN conjugates.
module twiddle_fetch
    import fft_pkg::*;
#(
    parameter int N        = 16,
    parameter int LOG_N    = 4,
    parameter int TF_WIDTH = fft_pkg::TF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [LOG_N-2:0]         tf_addr,
    output logic                     tf_addr_nd,
    input  logic [TF_WIDTH-1:0]      tf_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TF_WIDTH-1:0]      out_tf,
    output logic [$clog2(LOG_N)-1:0] out_stage,
    output logic [LOG_N-2:0]         out_bfly,
    output logic                     busy,
    output logic                     done
);

    localparam int BW = LOG_N - 1;
    localparam int SW = $clog2(LOG_N);
    localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

    tf_state_e     state_q;
    tf_state_e     state_d;
    logic [BW-1:0] b_q;
    logic [SW-1:0] s_q;
    logic          pend_q;
    logic [BW-1:0] pend_b_q;
    logic [SW-1:0] pend_s_q;
    logic          issue;
    logic          last_issue;
    logic          pop;
    logic          head_last;
    logic          credit;
    logic [1:0]    fifo_cnt;
    logic [2:0]    occ;
    logic [BW-1:0] b_mask;
    logic [BW-1:0] addr_raw;
    logic [TF_WIDTH-1:0] cap_tf;

    assign pop        = out_valid && out_ready;
    assign last_issue = (b_q == B_LAST) && (s_q == S_LAST);
    assign head_last  = (out_bfly == B_LAST) && (out_stage == S_LAST);

    // A read may only launch if its data is guaranteed a FIFO slot even
    // if the consumer stalls from now on; a pop this cycle frees one.
    assign occ    = {1'b0, fifo_cnt} + {2'b00, pend_q} - {2'b00, pop};
    assign credit = (occ < 3'd2);

    // Stage s repeats every 2^s butterflies, spread across the ROM.
    assign b_mask   = ~({BW{1'b1}} << s_q);
    assign addr_raw = (b_q & b_mask) << (BW - int'(s_q));

`ifdef TWIDDLE_FETCH_CONJ_EN
    assign cap_tf = tf_conj(tf_in);
`else
    assign cap_tf = tf_in;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only honoured from IDLE, so re-starts are ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: the first strobe launches in the start cycle itself.
    always_comb begin
        issue = 1'b0;
        if (rst_n && credit) begin
            if (state_q == ST_RUN) begin
                issue = 1'b1;
            end else if ((state_q == ST_IDLE) && start) begin
                issue = 1'b1;
            end
        end
        tf_addr_nd = issue;
        tf_addr    = issue ? addr_raw : '0;
        busy       = (state_q != ST_IDLE);
    end

    // Schedule counters and the one-deep read-in-flight tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q      <= '0;
            s_q      <= '0;
            pend_q   <= 1'b0;
            pend_b_q <= '0;
            pend_s_q <= '0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                pend_b_q <= b_q;
                pend_s_q <= s_q;
                if (b_q == B_LAST) begin
                    b_q <= '0;
                    s_q <= last_issue ? '0 : s_q + 1'b1;
                end else begin
                    b_q <= b_q + 1'b1;
                end
            end
        end
    end

    // Done pulses the cycle after the final handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state_q == ST_DRAIN) && pop && head_last;
        end
    end

    tf_skid_fifo #(
        .DW (TF_WIDTH),
        .SW (SW),
        .BW (BW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pend_q),
        .push_tf    (cap_tf),
        .push_stage (pend_s_q),
        .push_bfly  (pend_b_q),
        .pop        (pop),
        .head_valid (out_valid),
        .head_tf    (out_tf),
        .head_stage (out_stage),
        .head_bfly  (out_bfly),
        .count      (fifo_cnt)
    );

endmodule
